// File: rtl/div_scale_ctrl_pkg.sv
// Shared constants, FSM encoding and index helper for the volts/div scale controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_scale_ctrl_pkg;

   localparam int DIV_INDEX_W           = 3;

   localparam int DEF_MAX_INDEX         = 7;
   localparam int DEF_DEFAULT_INDEX     = 3;
   localparam int DEF_DEBOUNCE_FRAMES   = 3;
   localparam int DEF_REPEAT_DELAY      = 30;
   localparam int DEF_REPEAT_RATE       = 6;
   localparam int DEF_BLINK_FRAMES      = 15;
   localparam int DEF_BLINK_TOGGLES     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   // One saturating step of the scale index, up or down.
   function automatic logic [DIV_INDEX_W-1:0] sat_step(
      input logic [DIV_INDEX_W-1:0] idx,
      input logic                   up,
      input logic [DIV_INDEX_W-1:0] max_idx
   );
      logic [DIV_INDEX_W-1:0] r;
      r = idx;
      if (up) begin
         if (idx < max_idx) r = idx + DIV_INDEX_W'(1);
      end else begin
         if (idx != '0) r = idx - DIV_INDEX_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/div_btn_debounce.sv
// Two-flop synchroniser plus frame-tick debouncer for one raw push-button.
// Latency: 2 cycles sync + DEBOUNCE_FRAMES consecutive frame_ticks before level_o follows.
// Backpressure: none; free-running, output is a level.
module div_btn_debounce #(
   parameter int DEBOUNCE_FRAMES = 3
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic frame_tick_i,
   input  logic btn_i,
   output logic level_o
);
   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

   logic [1:0]    sync_q;
   logic [1:0]    fill_q;
   logic          armed_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic          synced;

   assign synced  = sync_q[1];
   assign level_o = level_q;

   // Synchronise the raw button and arm only after it has been seen low once the
   // sync pipe holds real samples, so a button held through reset never registers
   // as a fresh press.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         sync_q  <= '0;
         fill_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         if (fill_q == 2'd2 && !synced) armed_q <= 1'b1;
      end
   end

   // Accept a new level after it has differed at DEBOUNCE_FRAMES consecutive ticks;
   // any agreeing tick restarts the count.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else if (frame_tick_i) begin
         if (armed_q && (synced != level_q)) begin
            if (cnt_q == CW'(DEBOUNCE_FRAMES - 1)) begin
               level_q <= synced;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/div_scale_ctrl.sv
// Volts/div index controller: debounced up/down buttons with auto-repeat, saturating index, label blink.
// Latency: first step 1 cycle after the debounced level rises; div_changed and index move together.
// Backpressure: none; all timing is paced by frame_tick.
module div_scale_ctrl
   import div_scale_ctrl_pkg::*;
#(
   parameter int MAX_INDEX       = DEF_MAX_INDEX,
   parameter int DEFAULT_INDEX   = DEF_DEFAULT_INDEX,
   parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
   parameter int BLINK_TOGGLES   = DEF_BLINK_TOGGLES
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic                   frame_tick,
   input  logic                   btn_up,
   input  logic                   btn_down,
   output logic [DIV_INDEX_W-1:0] div_index,
   output logic                   div_changed,
   output logic                   label_on
);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int BW   = $clog2(BLINK_FRAMES + 1);
   localparam int TW   = $clog2(BLINK_TOGGLES + 1);
   localparam logic [DIV_INDEX_W-1:0] MAX_IDX = DIV_INDEX_W'(MAX_INDEX);

   logic                   up_lvl;
   logic                   dn_lvl;
   state_t                 state_q;
   logic                   dir_up_q;
   logic [RW-1:0]          rep_cnt_q;
   logic [DIV_INDEX_W-1:0] idx_q;
   logic [DIV_INDEX_W-1:0] idx_d;
   logic                   chg_q;
   logic                   label_q;
   logic [TW-1:0]          toggle_q;
   logic [BW-1:0]          phase_q;
   logic                   held;
   logic                   other;
   logic                   step_req;
   logic                   step_up;

   div_btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_up (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .frame_tick_i (frame_tick),
      .btn_i        (btn_up),
      .level_o      (up_lvl)
   );

   div_btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_dn (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .frame_tick_i (frame_tick),
      .btn_i        (btn_down),
      .level_o      (dn_lvl)
   );

   assign held  = dir_up_q ? up_lvl : dn_lvl;
   assign other = dir_up_q ? dn_lvl : up_lvl;

   // Decide whether this cycle issues a step; transition cycles (release/lock) never step.
   always_comb begin
      step_req = 1'b0;
      step_up  = dir_up_q;
      case (state_q)
         ST_IDLE: begin
            if (up_lvl ^ dn_lvl) begin
               step_req = 1'b1;
               step_up  = up_lvl;
            end
         end
         ST_HOLD: begin
            if (held && !other && frame_tick && rep_cnt_q == RW'(REPEAT_DELAY - 1))
               step_req = 1'b1;
         end
         ST_REPEAT: begin
            if (held && !other && frame_tick && rep_cnt_q == RW'(REPEAT_RATE - 1))
               step_req = 1'b1;
         end
         default: ;
      endcase
      idx_d = sat_step(idx_q, step_up, MAX_IDX);
   end

   // Button sequencing: first step, delayed auto-repeat, and a lock-out while both are down.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         dir_up_q  <= 1'b0;
         rep_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rep_cnt_q <= '0;
               if (up_lvl ^ dn_lvl) begin
                  state_q  <= ST_HOLD;
                  dir_up_q <= up_lvl;
               end else if (up_lvl && dn_lvl) begin
                  state_q <= ST_LOCK;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (!held) begin
                  state_q   <= ST_IDLE;
                  rep_cnt_q <= '0;
               end else if (other) begin
                  state_q   <= ST_LOCK;
                  rep_cnt_q <= '0;
               end else if (frame_tick) begin
                  if (step_req) begin
                     state_q   <= ST_REPEAT;
                     rep_cnt_q <= '0;
                  end else begin
                     rep_cnt_q <= rep_cnt_q + RW'(1);
                  end
               end
            end
            ST_LOCK: begin
               if (!up_lvl && !dn_lvl) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Apply steps to the index; flag a change only when saturation did not swallow it.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         idx_q <= DIV_INDEX_W'(DEFAULT_INDEX);
         chg_q <= 1'b0;
      end else begin
         chg_q <= 1'b0;
         if (step_req) begin
            idx_q <= idx_d;
            chg_q <= (idx_d != idx_q);
         end
      end
   end

   // Blink the label after each real change; the last toggle always leaves it lit.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         label_q  <= 1'b1;
         toggle_q <= '0;
         phase_q  <= '0;
      end else if (chg_q) begin
         label_q  <= 1'b0;
         toggle_q <= TW'(BLINK_TOGGLES);
         phase_q  <= '0;
      end else if (toggle_q != '0 && frame_tick) begin
         if (phase_q == BW'(BLINK_FRAMES - 1)) begin
            phase_q  <= '0;
            toggle_q <= toggle_q - TW'(1);
            label_q  <= (toggle_q == TW'(1)) ? 1'b1 : ~label_q;
         end else begin
            phase_q <= phase_q + BW'(1);
         end
      end
   end

   assign div_index   = idx_q;
   assign div_changed = chg_q;
   assign label_on    = label_q;

endmodule

// File: tb/tb_div_scale_ctrl.sv
// Directed bench for div_scale_ctrl: stimulus pushes expected new indices, a monitor pops on div_changed.
// Frame ticks every FT cycles; all inputs are driven on the falling edge.
// Timing checks use frame-tick counts captured when each div_changed pulse is seen.
module tb_div_scale_ctrl;
   localparam int FT = 8;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       frame_tick;
   logic       btn_up;
   logic       btn_down;
   logic [2:0] div_index;
   logic       div_changed;
   logic       label_on;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int tick_cnt = 0;
   int chg_cnt  = 0;
   int chg_tick = 0;
   logic prev_chg = 1'b0;
   int fcnt = 0;
   int t0;
   int t1;

   div_scale_ctrl dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .frame_tick  (frame_tick),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .div_index   (div_index),
      .div_changed (div_changed),
      .label_on    (label_on)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      frame_tick = 1'b0;
      forever begin
         @(negedge CLOCK);
         fcnt = (fcnt + 1) % FT;
         frame_tick = (fcnt == 0);
      end
   end

   always @(posedge CLOCK) if (frame_tick) tick_cnt <= tick_cnt + 1;

   // Scoreboard monitor
   always @(negedge CLOCK) begin
      if (RESET) begin
         prev_chg = 1'b0;
      end else begin
         if (div_changed) begin
            check("chg_width", int'(prev_chg), 0);
            check("chg_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("chg_index", int'(div_index), exp_q.pop_front());
            chg_tick = tick_cnt;
            chg_cnt++;
         end
         prev_chg = div_changed;
      end
   end

   task automatic wait_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK);
         while (frame_tick !== 1'b1) @(posedge CLOCK);
      end
   endtask

   task automatic wait_chg(input string name, input int maxc);
      int c0;
      int n;
      c0 = chg_cnt;
      n = 0;
      while (chg_cnt == c0 && n < maxc) begin
         @(negedge CLOCK);
         n++;
      end
      check(name, int'(chg_cnt != c0), 1);
   endtask

   initial begin
      RESET = 1'b1;
      btn_up = 1'b0;
      btn_down = 1'b0;
      repeat (4) @(negedge CLOCK);
      check("rst_index", int'(div_index), 3);
      check("rst_changed", int'(div_changed), 0);
      check("rst_label", int'(label_on), 1);
      RESET = 1'b0;
      wait_frames(2);

      // Single press: 3 -> 4, label blinks 0,1,0,1 then stays 1
      wait_frames(1);
      @(negedge CLOCK);
      btn_up = 1'b1;
      t0 = tick_cnt;
      exp_q.push_back(4);
      wait_chg("t1_chg_seen", 200);
      check("t1_latency_ticks", chg_tick - t0, 3);
      wait_frames(7);
      @(negedge CLOCK);
      check("t1_label_ph0", int'(label_on), 0);
      btn_up = 1'b0;
      wait_frames(15);
      @(negedge CLOCK);
      check("t1_label_ph1", int'(label_on), 1);
      wait_frames(15);
      @(negedge CLOCK);
      check("t1_label_ph2", int'(label_on), 0);
      wait_frames(15);
      @(negedge CLOCK);
      check("t1_label_ph3", int'(label_on), 1);
      wait_frames(15);
      @(negedge CLOCK);
      check("t1_label_end", int'(label_on), 1);
      wait_frames(20);
      @(negedge CLOCK);
      check("t1_label_steady", int'(label_on), 1);
      check("t1_index", int'(div_index), 4);

      // Hold up: 4->5->6->7 at 0, +30, +36; later steps saturate silently
      wait_frames(1);
      @(negedge CLOCK);
      btn_up = 1'b1;
      exp_q.push_back(5);
      exp_q.push_back(6);
      exp_q.push_back(7);
      wait_chg("t2_chg1_seen", 200);
      t1 = chg_tick;
      wait_chg("t2_chg2_seen", 400);
      check("t2_repeat_delay", chg_tick - t1, 30);
      t1 = chg_tick;
      wait_chg("t2_chg3_seen", 200);
      check("t2_repeat_rate", chg_tick - t1, 6);
      wait_frames(30);
      @(negedge CLOCK);
      btn_up = 1'b0;
      wait_frames(10);
      @(negedge CLOCK);
      check("t2_index_sat", int'(div_index), 7);

      // Short glitches on btn_down never get through the debouncer
      for (int i = 0; i < 6; i++) begin
         wait_frames(1);
         @(negedge CLOCK);
         btn_down = 1'b1;
         wait_frames((i % 2) + 1);
         @(negedge CLOCK);
         btn_down = 1'b0;
         wait_frames(1);
      end
      wait_frames(10);
      @(negedge CLOCK);
      check("t3_index", int'(div_index), 7);

      // Hold down then up during HOLD -> LOCK until both released
      wait_frames(1);
      @(negedge CLOCK);
      btn_down = 1'b1;
      exp_q.push_back(6);
      wait_chg("t4_chg_seen", 200);
      wait_frames(10);
      @(negedge CLOCK);
      btn_up = 1'b1;
      wait_frames(50);
      @(negedge CLOCK);
      check("t4_lock_index", int'(div_index), 6);
      btn_up = 1'b0;
      wait_frames(20);
      @(negedge CLOCK);
      check("t4_lock_index2", int'(div_index), 6);
      btn_down = 1'b0;
      wait_frames(10);
      wait_frames(1);
      @(negedge CLOCK);
      btn_up = 1'b1;
      exp_q.push_back(7);
      wait_chg("t4_after_lock_seen", 200);
      wait_frames(10);
      @(negedge CLOCK);
      btn_up = 1'b0;
      wait_frames(10);
      @(negedge CLOCK);
      check("t4_index", int'(div_index), 7);

      // Run down to 0, then a press at 0 changes nothing
      wait_frames(1);
      @(negedge CLOCK);
      btn_down = 1'b1;
      for (int v = 6; v >= 0; v--) exp_q.push_back(v);
      wait_frames(70);
      @(negedge CLOCK);
      btn_down = 1'b0;
      wait_frames(10);
      @(negedge CLOCK);
      check("t5_index_zero", int'(div_index), 0);
      check("t5_pending", exp_q.size(), 0);
      wait_frames(80);
      @(negedge CLOCK);
      check("t5_label_idle", int'(label_on), 1);
      wait_frames(1);
      @(negedge CLOCK);
      btn_down = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_frames(2);
         @(negedge CLOCK);
         check("t5_label_at_zero", int'(label_on), 1);
      end
      btn_down = 1'b0;
      wait_frames(10);
      @(negedge CLOCK);
      check("t5_index_still_zero", int'(div_index), 0);

      // Reset during REPEAT with btn_up held; no step until re-press
      wait_frames(1);
      @(negedge CLOCK);
      btn_up = 1'b1;
      exp_q.push_back(1);
      exp_q.push_back(2);
      wait_frames(36);
      @(negedge CLOCK);
      check("t6_pre_reset_pending", exp_q.size(), 0);
      check("t6_pre_reset_index", int'(div_index), 2);
      RESET = 1'b1;
      repeat (3) @(negedge CLOCK);
      check("t6_rst_index", int'(div_index), 3);
      check("t6_rst_label", int'(label_on), 1);
      RESET = 1'b0;
      @(negedge CLOCK);
      check("t6_post_rst_index", int'(div_index), 3);
      wait_frames(40);
      @(negedge CLOCK);
      check("t6_held_no_step", int'(div_index), 3);
      check("t6_held_label", int'(label_on), 1);
      btn_up = 1'b0;
      wait_frames(10);
      wait_frames(1);
      @(negedge CLOCK);
      btn_up = 1'b1;
      exp_q.push_back(4);
      wait_chg("t6_repress_seen", 200);
      wait_frames(10);
      @(negedge CLOCK);
      btn_up = 1'b0;
      wait_frames(70);
      @(negedge CLOCK);
      check("t6_index", int'(div_index), 4);
      check("t6_label_end", int'(label_on), 1);
      check("final_pending", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
